// File: rtl/sigma_pwm_dac.sv
// sigma_pwm_dac: 1-bit DAC with PWM, first/second-order sigma-delta and mute modes.
// One signed sample is consumed every 2^OSR_LOG2 clocks; mode changes land on sample boundaries.
module sigma_pwm_dac #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned OSR_LOG2 = 8
) (
    input  logic             clk,
    input  logic             rst_an,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ack,
    input  logic [1:0]       mode,
    output logic             dacout,
    output logic             underrun
);
    typedef enum logic [1:0] {
        M_PWM  = 2'd0,
        M_SD1  = 2'd1,
        M_SD2  = 2'd2,
        M_MUTE = 2'd3
    } mode_t;

    localparam int IW = WIDTH + 4;
    localparam int EW = WIDTH + 6;
    localparam logic signed [EW-1:0] LIM  = EW'((1 << (WIDTH + 2)) - 1);
    localparam logic signed [EW-1:0] NLIM = -LIM;
    localparam logic signed [EW-1:0] HALF = EW'(1 << (WIDTH - 1));

    logic [OSR_LOG2-1:0]     cnt, cnt_nxt;
    logic signed [WIDTH-1:0] sample, sample_nxt;
    mode_t                   amode, amode_nxt, mode_in;
    logic [WIDTH-1:0]        acc, acc_nxt;
    logic signed [IW-1:0]    i1, i1_nxt, i2, i2_nxt;
    logic                    dac_nxt, underrun_nxt;
    logic                    boundary, mode_chg;
    logic [WIDTH-1:0]        u_cur, u_nxt;
    logic [WIDTH:0]          acc_sum;
    logic signed [EW-1:0]    y, s1, s2;
    logic signed [IW-1:0]    i1_sat, i2_sat;

    function automatic logic signed [IW-1:0] sat(input logic signed [EW-1:0] v);
        if (v > LIM)
            return LIM[IW-1:0];
        else if (v < NLIM)
            return NLIM[IW-1:0];
        return v[IW-1:0];
    endfunction

    assign boundary = (cnt == '1);
    assign din_ack  = boundary;
    assign mode_in  = mode_t'(mode);

    always_comb begin
        cnt_nxt      = cnt + OSR_LOG2'(1);
        sample_nxt   = sample;
        underrun_nxt = underrun;
        amode_nxt    = amode;
        if (boundary) begin
            amode_nxt = mode_in;
            if (din_valid)
                sample_nxt = din;
            else
                underrun_nxt = 1'b1;
        end
        mode_chg = boundary && (mode_in != amode);

        // Offset-binary view of the sample: MSB inverted
        u_cur = {~sample[WIDTH-1], sample[WIDTH-2:0]};
        u_nxt = {~sample_nxt[WIDTH-1], sample_nxt[WIDTH-2:0]};

        acc_sum = {1'b0, acc} + {1'b0, u_cur};
        y       = dacout ? HALF : -HALF;
        s1      = {{(EW-IW){i1[IW-1]}}, i1} + {{(EW-WIDTH){sample[WIDTH-1]}}, sample} - y;
        i1_sat  = sat(s1);
        s2      = {{(EW-IW){i2[IW-1]}}, i2} + {{(EW-IW){i1_sat[IW-1]}}, i1_sat} - y;
        i2_sat  = sat(s2);

        acc_nxt = acc;
        i1_nxt  = i1;
        i2_nxt  = i2;
        if (amode == M_SD1)
            acc_nxt = acc_sum[WIDTH-1:0];
        if (amode == M_SD2) begin
            i1_nxt = i1_sat;
            i2_nxt = i2_sat;
        end
        if (mode_chg) begin
            acc_nxt = '0;
            i1_nxt  = '0;
            i2_nxt  = '0;
        end

        // Output is chosen by the mode in force during the clock being entered
        dac_nxt = 1'b0;
        case (amode_nxt)
            M_PWM:  dac_nxt = (cnt_nxt[OSR_LOG2-1 -: WIDTH] < u_nxt);
            M_SD1:  dac_nxt = mode_chg ? 1'b0 : acc_sum[WIDTH];
            M_SD2:  dac_nxt = mode_chg ? 1'b0 : ~i2_sat[IW-1];
            M_MUTE: dac_nxt = mode_chg ? 1'b1 : ~dacout;
            default: dac_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            cnt      <= '0;
            sample   <= '0;
            amode    <= M_PWM;
            acc      <= '0;
            i1       <= '0;
            i2       <= '0;
            dacout   <= 1'b0;
            underrun <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            sample   <= sample_nxt;
            amode    <= amode_nxt;
            acc      <= acc_nxt;
            i1       <= i1_nxt;
            i2       <= i2_nxt;
            dacout   <= dac_nxt;
            underrun <= underrun_nxt;
        end
    end
endmodule
